// File: rtl/general_demux.sv
// Two-lane demultiplexer: each accepted word is routed by in_sel into lane A or lane B.
// Each lane is an independent circular FIFO of DEPTH entries with valid/ready on both sides.
module general_demux #(
    parameter int WORDSIZE = 64,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORDSIZE-1:0] in_data,
    input  logic                in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WORDSIZE-1:0] out_a_data,
    output logic                out_a_valid,
    input  logic                out_a_ready,
    output logic [WORDSIZE-1:0] out_b_data,
    output logic                out_b_valid,
    input  logic                out_b_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]       wptr_q  [2];
    logic [PW-1:0]       wptr_d  [2];
    logic [PW-1:0]       rptr_q  [2];
    logic [PW-1:0]       rptr_d  [2];
    logic [CW-1:0]       count_q [2];
    logic [CW-1:0]       count_d [2];
    logic [WORDSIZE-1:0] mem_q   [2][DEPTH];
    logic [WORDSIZE-1:0] mem_d   [2][DEPTH];

    logic [1:0] full_s;
    logic [1:0] empty_s;
    logic [1:0] push_s;
    logic [1:0] pop_s;
    logic [1:0] out_ready_s;

    // Lane status, handshakes and exposed head words.
    always_comb begin
        out_ready_s = {out_b_ready, out_a_ready};
        for (int i = 0; i < 2; i++) begin
            full_s[i]  = (count_q[i] == CW'(DEPTH));
            empty_s[i] = (count_q[i] == {CW{1'b0}});
            pop_s[i]   = !empty_s[i] && out_ready_s[i];
        end
        // in_ready depends only on in_sel and registered counts, so a pop cannot free a slot for a same-cycle push.
        if (in_sel) begin
            in_ready = !full_s[1];
        end else begin
            in_ready = !full_s[0];
        end
        push_s[0] = in_valid && in_ready && !in_sel;
        push_s[1] = in_valid && in_ready && in_sel;

        out_a_valid = !empty_s[0];
        out_b_valid = !empty_s[1];
        if (empty_s[0]) begin
            out_a_data = {WORDSIZE{1'b0}};
        end else begin
            out_a_data = mem_q[0][rptr_q[0]];
        end
        if (empty_s[1]) begin
            out_b_data = {WORDSIZE{1'b0}};
        end else begin
            out_b_data = mem_q[1][rptr_q[1]];
        end
    end

    // Next-state for pointers, counts and storage of both lanes.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wptr_d[i]  = wptr_q[i];
            rptr_d[i]  = rptr_q[i];
            count_d[i] = count_q[i];
            for (int j = 0; j < DEPTH; j++) begin
                mem_d[i][j] = mem_q[i][j];
            end
            if (push_s[i]) begin
                mem_d[i][wptr_q[i]] = in_data;
                wptr_d[i] = (wptr_q[i] == PW'(DEPTH - 1)) ? {PW{1'b0}} : wptr_q[i] + PW'(1);
            end else begin
                wptr_d[i] = wptr_q[i];
            end
            if (pop_s[i]) begin
                rptr_d[i] = (rptr_q[i] == PW'(DEPTH - 1)) ? {PW{1'b0}} : rptr_q[i] + PW'(1);
            end else begin
                rptr_d[i] = rptr_q[i];
            end
            case ({push_s[i], pop_s[i]})
                2'b10:   count_d[i] = count_q[i] + CW'(1);
                2'b01:   count_d[i] = count_q[i] - CW'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    // Control state; clearing counts discards stored words immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wptr_q[i]  <= {PW{1'b0}};
                rptr_q[i]  <= {PW{1'b0}};
                count_q[i] <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                wptr_q[i]  <= wptr_d[i];
                rptr_q[i]  <= rptr_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    // Storage is not reset; empty lanes mask their contents to zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[i][j] <= mem_d[i][j];
            end
        end
    end

endmodule

// File: tb/tb_general_demux.sv
// Directed bench for general_demux with a per-lane scoreboard of expected words.
module tb_general_demux;

    localparam int W     = 64;
    localparam int DEPTH = 2;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_a_data;
    logic         out_a_valid;
    logic         out_a_ready;
    logic [W-1:0] out_b_data;
    logic         out_b_valid;
    logic         out_b_ready;

    int tests_run;
    int tests_failed;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    general_demux #(.WORDSIZE(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_a_data  (out_a_data),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_b_data  (out_b_data),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs mid-cycle against the scoreboard, then update it for the coming edge.
    task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                        input logic ra, input logic rb);
        logic         exp_rdy;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        logic         pop_a;
        logic         pop_b;
        in_valid    = v;
        in_sel      = s;
        in_data     = d;
        out_a_ready = ra;
        out_b_ready = rb;
        @(negedge clk);
        exp_rdy = s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        exp_a   = (qa.size() != 0) ? qa[0] : {W{1'b0}};
        exp_b   = (qb.size() != 0) ? qb[0] : {W{1'b0}};
        check("in_ready",    W'(in_ready),    W'(exp_rdy));
        check("out_a_valid", W'(out_a_valid), W'(qa.size() != 0));
        check("out_a_data",  out_a_data,      exp_a);
        check("out_b_valid", W'(out_b_valid), W'(qb.size() != 0));
        check("out_b_data",  out_b_data,      exp_b);
        pop_a = ra && (qa.size() != 0);
        pop_b = rb && (qb.size() != 0);
        if (pop_a) void'(qa.pop_front());
        if (pop_b) void'(qb.pop_front());
        if (v && exp_rdy) begin
            if (s) qb.push_back(d);
            else   qa.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_sel       = 1'b0;
        in_data      = {W{1'b0}};
        out_a_ready  = 1'b0;
        out_b_ready  = 1'b0;
        #1;
        check("rst_in_ready",    W'(in_ready),    W'(1'b1));
        check("rst_out_a_valid", W'(out_a_valid), W'(1'b0));
        check("rst_out_b_valid", W'(out_b_valid), W'(1'b0));
        check("rst_out_a_data",  out_a_data,      {W{1'b0}});
        check("rst_out_b_data",  out_b_data,      {W{1'b0}});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Routing to each lane.
        step(1'b1, 1'b0, 64'h11, 1'b1, 1'b1);
        step(1'b1, 1'b1, 64'h22, 1'b1, 1'b1);
        step(1'b0, 1'b0, 64'h0,  1'b1, 1'b1);
        step(1'b0, 1'b0, 64'h0,  1'b1, 1'b1);

        // Fill lane A, verify lane B still accepts.
        step(1'b1, 1'b0, 64'hA1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'hA2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'hA3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'hB1, 1'b0, 1'b1);

        // Full lane with pop: no push this cycle, push next cycle.
        step(1'b1, 1'b0, 64'hA4, 1'b1, 1'b1);
        step(1'b1, 1'b0, 64'hA5, 1'b0, 1'b1);
        step(1'b0, 1'b0, 64'h0,  1'b1, 1'b1);
        step(1'b0, 1'b0, 64'h0,  1'b1, 1'b1);
        step(1'b0, 1'b0, 64'h0,  1'b1, 1'b1);

        // Streaming through lane B with wrapping pointers.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, W'(i), 1'b0, 1'b1);
        end
        step(1'b0, 1'b1, 64'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 64'h0, 1'b0, 1'b1);

        // Idle input with toggling select/data, ready on empty lanes.
        step(1'b0, 1'b1, 64'hFF, 1'b1, 1'b1);
        step(1'b0, 1'b0, 64'hEE, 1'b0, 1'b0);

        // Asynchronous reset mid-operation.
        step(1'b1, 1'b0, 64'hC1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'hC2, 1'b0, 1'b0);
        in_valid = 1'b0;
        in_sel   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_a_valid", W'(out_a_valid), W'(1'b0));
        check("arst_out_a_data",  out_a_data,      {W{1'b0}});
        check("arst_in_ready",    W'(in_ready),    W'(1'b1));
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 64'h33, 1'b0, 1'b0);
        step(1'b0, 1'b0, 64'h0,  1'b1, 1'b0);
        step(1'b0, 1'b0, 64'h0,  1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
